// File: rtl/trdb_priority_pipe.sv
// rtl/trdb_priority_pipe.sv - E-trace packet-priority unit: lc/tc/nc window, branch map, resync, descriptor FIFO
// Optional feature macro: TRDB_PRIORITY_RESYNC_CYCLES_EN (resync counts cycles instead of instructions)
module trdb_priority_pipe #(
  parameter int BRANCH_MAP_LEN = 31,
  parameter int RESYNC_MAX     = 16'hFFFF,
  parameter int FIFO_DEPTH     = 4,
  parameter int BCW            = $clog2(BRANCH_MAP_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      inst_valid_i,
  output logic                      in_ready_o,
  input  logic                      qualified_i,
  input  logic                      exception_i,
  input  logic                      updiscon_i,
  input  logic                      branch_i,
  input  logic                      branch_taken_i,
  input  logic                      privchange_i,
  input  logic                      context_change_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [1:0]                format_o,
  output logic [1:0]                subformat_o,
  output logic                      thaddr_o,
  output logic                      cause_mux_o,
  output logic                      tval_mux_o,
  output logic                      addr_present_o,
  output logic [BCW-1:0]            branch_cnt_o,
  output logic [BRANCH_MAP_LEN-1:0] branch_map_o,
  output logic [1:0]                qual_status_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0]    RMAX     = 16'(RESYNC_MAX);
  localparam logic [BCW-1:0] FULL_CNT = BCW'(BRANCH_MAP_LEN);

  localparam logic [1:0] FMT_F1 = 2'd1;
  localparam logic [1:0] FMT_F2 = 2'd2;
  localparam logic [1:0] FMT_F3 = 2'd3;
  localparam logic [1:0] SF0    = 2'd0;
  localparam logic [1:0] SF1    = 2'd1;
  localparam logic [1:0] QS_ENDED_REP = 2'b01;

  typedef struct packed {
    logic q;
    logic exception;
    logic updiscon;
    logic branch;
    logic taken;
    logic privchange;
    logic context_change;
  } slot_t;

  typedef struct packed {
    logic [1:0]                format;
    logic [1:0]                subformat;
    logic                      thaddr;
    logic                      cause_mux;
    logic                      tval_mux;
    logic                      addr_present;
    logic [BCW-1:0]            branch_cnt;
    logic [BRANCH_MAP_LEN-1:0] branch_map;
    logic [1:0]                qual_status;
  } desc_t;

  // The incoming instruction is nc; the newest registered one is tc, the one before it lc.
  slot_t nc;
  slot_t tc;
  logic  tc_valid;
  logic  lc_valid;
  logic  lc_q;
  logic  lc_exception;
  logic  lc_updiscon;

  logic [BCW-1:0]            cnt;
  logic [BRANCH_MAP_LEN-1:0] map;
  logic [15:0]               resync_cnt;

  logic                      accept;
  logic                      tc_q;
  logic                      lc_qual;
  logic                      first_qualified;
  logic                      final_qualified;
  logic                      resync_exp;
  logic [BCW-1:0]            cap_cnt;
  logic [BRANCH_MAP_LEN-1:0] cap_map;
  logic                      gen;
  logic                      is_f3;
  logic                      count_tick;
  desc_t                     desc;

  desc_t      mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  desc_t       head;

  assign nc = '{q:              qualified_i,
                exception:      exception_i,
                updiscon:       updiscon_i,
                branch:         branch_i,
                taken:          branch_taken_i,
                privchange:     privchange_i,
                context_change: context_change_i};

  assign accept          = inst_valid_i && in_ready_o;
  assign tc_q            = tc_valid && tc.q;
  assign lc_qual         = lc_valid && lc_q;
  assign first_qualified = tc_q && !lc_qual;
  assign final_qualified = tc_q && !nc.q;
  assign resync_exp      = resync_cnt >= RMAX;

  // tc's own branch goes into the map before the decision so its packet carries it.
  always_comb begin
    cap_cnt = cnt;
    cap_map = map;
    if (tc_q && tc.branch && (cnt < FULL_CNT)) begin
      for (int k = 0; k < BRANCH_MAP_LEN; k++) begin
        if (k == int'(cnt)) cap_map[k] = !tc.taken;
      end
      cap_cnt = cnt + 1'b1;
    end
  end

  always_comb begin
    desc            = '0;
    gen             = 1'b0;
    desc.branch_cnt = cap_cnt;
    desc.branch_map = cap_map;
    if (tc_q) begin
      if (lc_valid && lc_exception) begin
        gen            = 1'b1;
        desc.format    = FMT_F3;
        desc.subformat = SF1;
        desc.cause_mux = 1'b1;
        desc.tval_mux  = 1'b1;
      end else if (first_qualified || tc.privchange || tc.context_change ||
                   (resync_exp && cap_cnt == '0)) begin
        gen            = 1'b1;
        desc.format    = FMT_F3;
        desc.subformat = SF0;
      end else if (lc_valid && lc_updiscon) begin
        gen               = 1'b1;
        desc.format       = (cap_cnt == '0) ? FMT_F2 : FMT_F1;
        desc.addr_present = 1'b1;
      end else if (resync_exp) begin
        gen               = 1'b1;
        desc.format       = FMT_F1;
        desc.addr_present = 1'b1;
      end else if (nc.exception || nc.privchange || nc.context_change || final_qualified) begin
        gen               = 1'b1;
        desc.format       = (cap_cnt == '0) ? FMT_F2 : FMT_F1;
        desc.addr_present = 1'b1;
        desc.qual_status  = final_qualified ? QS_ENDED_REP : 2'b00;
      end else if (cap_cnt == FULL_CNT) begin
        gen         = 1'b1;
        desc.format = FMT_F1;
      end
    end
  end

  assign is_f3 = gen && (desc.format == FMT_F3);

`ifdef TRDB_PRIORITY_RESYNC_CYCLES_EN
  assign count_tick = tc_q;
`else
  assign count_tick = accept && tc_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tc           <= '0;
      tc_valid     <= 1'b0;
      lc_valid     <= 1'b0;
      lc_q         <= 1'b0;
      lc_exception <= 1'b0;
      lc_updiscon  <= 1'b0;
      cnt          <= '0;
      map          <= '0;
    end else if (accept) begin
      lc_valid     <= tc_valid;
      lc_q         <= tc.q;
      lc_exception <= tc.exception;
      lc_updiscon  <= tc.updiscon;
      tc           <= nc;
      tc_valid     <= 1'b1;
      if (gen) begin
        cnt <= '0;
        map <= '0;
      end else if (tc_q) begin
        cnt <= cap_cnt;
        map <= cap_map;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resync_cnt <= '0;
    end else if (accept && is_f3) begin
      resync_cnt <= '0;
    end else if (count_tick && resync_cnt < RMAX) begin
      resync_cnt <= resync_cnt + 16'd1;
    end
  end

  // Descriptor FIFO; the extra pointer bit separates full from empty.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push       = accept && gen;
  assign pop        = !fifo_empty && out_ready_i;
  assign in_ready_o = !fifo_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= desc;
  end

  assign head = fifo_empty ? '0 : mem[rptr[AW-1:0]];

  assign out_valid_o    = !fifo_empty;
  assign format_o       = head.format;
  assign subformat_o    = head.subformat;
  assign thaddr_o       = head.thaddr;
  assign cause_mux_o    = head.cause_mux;
  assign tval_mux_o     = head.tval_mux;
  assign addr_present_o = head.addr_present;
  assign branch_cnt_o   = head.branch_cnt;
  assign branch_map_o   = head.branch_map;
  assign qual_status_o  = head.qual_status;

endmodule

// File: tb/tb_trdb_priority_pipe.sv
// tb/tb_trdb_priority_pipe.sv - scoreboard bench for trdb_priority_pipe
module tb_trdb_priority_pipe;

  localparam int BML = 31;
  localparam int BCW = $clog2(BML + 1);
  localparam int RS  = 40;
`ifdef TRDB_PRIORITY_RESYNC_CYCLES_EN
  localparam int RS_K = (RS + 9) / 3;
`else
  localparam int RS_K = RS + 3;
`endif

  typedef struct packed {
    logic q, exc, upd, br, tk, prv, ctx;
  } ins_t;

  typedef struct packed {
    logic [1:0]     fmt;
    logic [1:0]     sub;
    logic           cause;
    logic           tval;
    logic           addr;
    logic [1:0]     qual;
    logic [BCW-1:0] cnt;
    logic [BML-1:0] map;
  } exp_t;

  localparam ins_t PLAIN   = 7'b1000000;
  localparam ins_t EXC     = 7'b1100000;
  localparam ins_t EXC_PRV = 7'b1100010;
  localparam ins_t PRV     = 7'b1000010;
  localparam ins_t BR_T    = 7'b1001100;
  localparam ins_t BR_N    = 7'b1001000;
  localparam ins_t UNQ     = 7'b0000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inst_valid = 1'b0;
  logic in_ready;
  ins_t cur_ins = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [1:0] format, subformat, qual_status;
  logic thaddr, cause_mux, tval_mux, addr_present;
  logic [BCW-1:0] branch_cnt;
  logic [BML-1:0] branch_map;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  trdb_priority_pipe #(
    .BRANCH_MAP_LEN(BML),
    .RESYNC_MAX(RS),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .inst_valid_i(inst_valid),
    .in_ready_o(in_ready),
    .qualified_i(cur_ins.q),
    .exception_i(cur_ins.exc),
    .updiscon_i(cur_ins.upd),
    .branch_i(cur_ins.br),
    .branch_taken_i(cur_ins.tk),
    .privchange_i(cur_ins.prv),
    .context_change_i(cur_ins.ctx),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .format_o(format),
    .subformat_o(subformat),
    .thaddr_o(thaddr),
    .cause_mux_o(cause_mux),
    .tval_mux_o(tval_mux),
    .addr_present_o(addr_present),
    .branch_cnt_o(branch_cnt),
    .branch_map_o(branch_map),
    .qual_status_o(qual_status)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t f3(input bit sf1);
    exp_t e = '0;
    e.fmt = 2'd3;
    e.sub = sf1 ? 2'd1 : 2'd0;
    e.cause = sf1;
    e.tval = sf1;
    return e;
  endfunction

  function automatic exp_t f1(input bit addr, input logic [1:0] qual, input int cnt, input logic [BML-1:0] map);
    exp_t e = '0;
    e.fmt = 2'd1;
    e.addr = addr;
    e.qual = qual;
    e.cnt = BCW'(cnt);
    e.map = map;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_desc", 64'(format), 64'hdead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("format", 64'(format), 64'(e.fmt));
        check("subformat", 64'(subformat), 64'(e.sub));
        check("flags", 64'({thaddr, cause_mux, tval_mux, addr_present}), 64'({1'b0, e.cause, e.tval, e.addr}));
        check("qual_status", 64'(qual_status), 64'(e.qual));
        check("branch_cnt", 64'(branch_cnt), 64'(e.cnt));
        check("branch_map", 64'(branch_map), 64'(e.map));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input ins_t i, input bit has_desc, input exp_t e);
    bit ok = 1'b0;
    cur_ins = i;
    inst_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 64'(0), 64'(1));
      inst_valid = 1'b0;
    end else begin
      if (has_desc) sb.push_back(e);
      @(posedge clk);
      #1;
      inst_valid = 1'b0;
      cur_ins = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    inst_valid = 1'b0;
    cur_ins = '0;
    idle(3);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t none = '0;
    @(posedge clk);
    #1;
    do_reset;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_format", 64'(format), 64'(0));
    check("rst_branch_cnt", 64'(branch_cnt), 64'(0));
    check("rst_branch_map", 64'(branch_map), 64'(0));
    idle(1);

    // sync on three plain qualified instructions
    send(PLAIN, 0, none);
    @(negedge clk);
    check("s1_no_valid_yet", 64'(out_valid), 64'(0));
    idle(1);
    send(PLAIN, 1, f3(0));
    @(negedge clk);
    check("s1_valid_latency", 64'(out_valid), 64'(1));
    idle(1);
    send(PLAIN, 0, none);
    idle(3);

    // full branch map of taken branches
    do_reset;
    send(PLAIN, 0, none);
    for (int j = 1; j <= BML; j++) send(BR_T, j == 1, f3(0));
    send(PLAIN, 1, f1(0, 2'b00, BML, '0));
    idle(3);

    // exception on instruction k reported when k+2 is accepted
    do_reset;
    send(PLAIN, 0, none);
    send(EXC, 1, f3(0));
    send(PLAIN, 0, none);
    send(PLAIN, 1, f3(1));
    idle(3);

    // qualification ends after a not-taken and a taken branch
    do_reset;
    send(PLAIN, 0, none);
    send(BR_N, 1, f3(0));
    send(BR_T, 0, none);
    send(UNQ, 1, f1(1, 2'b01, 2, 31'b01));
    send(UNQ, 0, none);
    idle(3);

    // backpressure fills the FIFO, then drains in order
    do_reset;
    out_ready = 1'b0;
    send(PLAIN, 0, none);
    send(EXC_PRV, 1, f3(0));
    send(PRV, 1, f3(0));
    send(PRV, 1, f3(1));
    send(PLAIN, 1, f3(0));
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    idle(3);
    @(negedge clk);
    check("bp_still_blocked", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    idle(1);
    out_ready = 1'b1;
    send(PLAIN, 0, none);
    idle(6);

    // resync expiry with accepts spaced three cycles apart
    do_reset;
    for (int k = 1; k <= RS_K; k++) begin
      send(PLAIN, (k == 2) || (k == RS_K), f3(0));
      @(negedge clk);
      if (k == RS_K - 1) check("rs_not_yet", 64'(out_valid), 64'(0));
      if (k == RS_K)     check("rs_f3_now", 64'(out_valid), 64'(1));
      idle(2);
    end
    idle(3);

    // reset with undrained descriptors discards them
    do_reset;
    out_ready = 1'b0;
    send(PLAIN, 0, none);
    send(PRV, 0, none);
    send(PLAIN, 0, none);
    @(negedge clk);
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    idle(1);
    do_reset;
    @(negedge clk);
    check("post_reset_valid", 64'(out_valid), 64'(0));
    check("post_reset_ready", 64'(in_ready), 64'(1));
    idle(1);
    out_ready = 1'b1;
    idle(4);

    for (int c = 0; c < 50 && sb.size() != 0; c++) idle(1);
    check("drain", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
